// File: rtl/cache_top.sv
// Direct-mapped, write-back / write-allocate cache controller with its own
// 256x8 line store, 8-entry tag array and a behavioural 64 KiB SDRAM model.
module cache_top #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 8,
    parameter int ADDR_WIDTH_SRAM = 8,
    parameter int TAG_SIZE        = 8,
    parameter int DEPTH           = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ADDR_WIDTH-1:0]      Address_cpu,
    input  logic [DATA_WIDTH-1:0]      DOut_cpu,
    input  logic                       wr_rd_cpu,
    input  logic                       cs_cpu,
    output logic                       rdy_cpu,
    output logic [DATA_WIDTH-1:0]      DIn_cpu,
    output logic [ADDR_WIDTH-1:0]      Address_sdram,
    output logic                       wr_rd_sdram,
    output logic                       mstrb_sdram,
    output logic                       mux_sel,
    output logic                       demux_sel,
    output logic                       wen_sram,
    output logic [ADDR_WIDTH_SRAM-1:0] address_cache_ctrl_sram
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = ADDR_WIDTH_SRAM - IDX_W;
    localparam int CNT_W = OFF_W + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COMPARE   = 3'd1,
        ACCESS    = 3'd2,
        WRITEBACK = 3'd3,
        ALLOCATE  = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [DATA_WIDTH-1:0]      wdata_q;
    logic                       wr_q;
    logic                       rdy_q;
    logic [DATA_WIDTH-1:0]      din_q;
    logic [DEPTH-1:0]           valid_q;
    logic [DEPTH-1:0]           dirty_q;
    logic [TAG_SIZE-1:0]        tag_q   [DEPTH];
    logic [DATA_WIDTH-1:0]      sram_q  [2**ADDR_WIDTH_SRAM];
    logic [DATA_WIDTH-1:0]      sdram_q [2**ADDR_WIDTH];

    logic [TAG_SIZE-1:0]        tag_s;
    logic [IDX_W-1:0]           idx_s;
    logic [OFF_W-1:0]           off_s;
    logic [OFF_W-1:0]           burst_off_s;
    logic                       phase_b_s;
    logic                       last_s;
    logic                       hit_s;
    logic                       accept_s;
    logic [ADDR_WIDTH_SRAM-1:0] sram_addr_s;
    logic [ADDR_WIDTH-1:0]      sdram_addr_s;
    logic                       wr_rd_sdram_s;
    logic                       mstrb_s;
    logic                       mux_sel_s;
    logic                       demux_sel_s;
    logic                       wen_s;
    logic [DATA_WIDTH-1:0]      sram_rd_s;
    logic [DATA_WIDTH-1:0]      sdram_rd_s;

    assign tag_s       = addr_q[ADDR_WIDTH-1 -: TAG_SIZE];
    assign idx_s       = addr_q[OFF_W +: IDX_W];
    assign off_s       = addr_q[OFF_W-1:0];
    assign burst_off_s = cnt_q[CNT_W-1:1];
    assign phase_b_s   = cnt_q[0];
    assign last_s      = (cnt_q == {CNT_W{1'b1}});
    assign hit_s       = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
    assign accept_s    = (state_q == IDLE) && rdy_q && cs_cpu;
    assign sram_rd_s   = sram_q[sram_addr_s];
    // SDRAM bytes are stored XORed with the low address byte, so a powered-up
    // all-zero array reads back as A[7:0] without any load step.
    assign sdram_rd_s  = sdram_q[sdram_addr_s] ^ sdram_addr_s[DATA_WIDTH-1:0];

    // Next-state, burst counter and per-state strobe decode
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sram_addr_s   = {idx_s, off_s};
        sdram_addr_s  = {ADDR_WIDTH{1'b0}};
        wr_rd_sdram_s = 1'b0;
        mstrb_s       = 1'b0;
        mux_sel_s     = 1'b0;
        demux_sel_s   = 1'b0;
        wen_s         = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = COMPARE;
                end else begin
                    state_d = IDLE;
                end
            end
            COMPARE: begin
                cnt_d = {CNT_W{1'b0}};
                if (hit_s) begin
                    state_d = ACCESS;
                end else if (dirty_q[idx_s]) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            ACCESS: begin
                if (wr_q) begin
                    wen_s = 1'b1;
                end else begin
                    wen_s = 1'b0;
                end
                state_d = IDLE;
            end
            WRITEBACK: begin
                sram_addr_s  = {idx_s, burst_off_s};
                sdram_addr_s = {tag_q[idx_s], idx_s, burst_off_s};
                if (!phase_b_s) begin
                    demux_sel_s   = 1'b1;
                    wr_rd_sdram_s = 1'b1;
                    mstrb_s       = 1'b1;
                end else begin
                    mstrb_s = 1'b0;
                end
                if (last_s) begin
                    state_d = ALLOCATE;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ALLOCATE: begin
                sram_addr_s  = {idx_s, burst_off_s};
                sdram_addr_s = {tag_s, idx_s, burst_off_s};
                if (!phase_b_s) begin
                    mstrb_s = 1'b1;
                end else begin
                    mux_sel_s = 1'b1;
                    wen_s     = 1'b1;
                end
                if (last_s) begin
                    state_d = ACCESS;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Controller state, request latch, line status and CPU read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            addr_q  <= {ADDR_WIDTH{1'b0}};
            wdata_q <= {DATA_WIDTH{1'b0}};
            wr_q    <= 1'b0;
            rdy_q   <= 1'b0;
            din_q   <= {DATA_WIDTH{1'b0}};
            valid_q <= {DEPTH{1'b0}};
            dirty_q <= {DEPTH{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // ready only on an idle cycle that is not itself taking a request
            rdy_q   <= (state_q == IDLE) && !accept_s;
            if (accept_s) begin
                addr_q  <= Address_cpu;
                wdata_q <= DOut_cpu;
                wr_q    <= wr_rd_cpu;
            end
            if ((state_q == ACCESS) && !wr_q) begin
                din_q <= sram_rd_s;
            end
            if ((state_q == ACCESS) && wr_q) begin
                dirty_q[idx_s] <= 1'b1;
            end
            if ((state_q == WRITEBACK) && last_s) begin
                dirty_q[idx_s] <= 1'b0;
            end
            if ((state_q == ALLOCATE) && last_s) begin
                valid_q[idx_s] <= 1'b1;
                dirty_q[idx_s] <= 1'b0;
            end
        end
    end

    // Tag store; meaningful only where the matching valid bit is set
    always_ff @(posedge clk) begin
        if (!rst && (state_q == ALLOCATE) && last_s) begin
            tag_q[idx_s] <= tag_s;
        end
    end

    // Cache line store, fed by the CPU or by an allocate burst
    always_ff @(posedge clk) begin
        if (!rst && wen_s) begin
            sram_q[sram_addr_s] <= mux_sel_s ? sdram_rd_s : wdata_q;
        end
    end

    // Backing SDRAM, written only by write-back strobes
    always_ff @(posedge clk) begin
        if (!rst && mstrb_s && wr_rd_sdram_s) begin
            sdram_q[sdram_addr_s] <= sram_rd_s ^ sdram_addr_s[DATA_WIDTH-1:0];
        end
    end

    assign rdy_cpu                 = rdy_q & ~rst;
    assign DIn_cpu                 = rst ? {DATA_WIDTH{1'b0}} : din_q;
    assign Address_sdram           = rst ? {ADDR_WIDTH{1'b0}} : sdram_addr_s;
    assign address_cache_ctrl_sram = rst ? {ADDR_WIDTH_SRAM{1'b0}} : sram_addr_s;
    assign wr_rd_sdram             = wr_rd_sdram_s & ~rst;
    assign mstrb_sdram             = mstrb_s & ~rst;
    assign mux_sel                 = mux_sel_s & ~rst;
    assign demux_sel               = demux_sel_s & ~rst;
    assign wen_sram                = wen_s & ~rst;

endmodule

// File: tb/tb_cache_top.sv
// Self-checking bench for cache_top: directed vector table, reset and
// request-ignore sequences, then random traffic against a cache model.
module tb_cache_top;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] Address_cpu;
    logic [7:0]  DOut_cpu;
    logic        wr_rd_cpu;
    logic        cs_cpu;
    logic        rdy_cpu;
    logic [7:0]  DIn_cpu;
    logic [15:0] Address_sdram;
    logic        wr_rd_sdram;
    logic        mstrb_sdram;
    logic        mux_sel;
    logic        demux_sel;
    logic        wen_sram;
    logic [7:0]  address_cache_ctrl_sram;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_top dut (
        .clk                     (clk),
        .rst                     (rst),
        .Address_cpu             (Address_cpu),
        .DOut_cpu                (DOut_cpu),
        .wr_rd_cpu               (wr_rd_cpu),
        .cs_cpu                  (cs_cpu),
        .rdy_cpu                 (rdy_cpu),
        .DIn_cpu                 (DIn_cpu),
        .Address_sdram           (Address_sdram),
        .wr_rd_sdram             (wr_rd_sdram),
        .mstrb_sdram             (mstrb_sdram),
        .mux_sel                 (mux_sel),
        .demux_sel               (demux_sel),
        .wen_sram                (wen_sram),
        .address_cache_ctrl_sram (address_cache_ctrl_sram)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        int          lat;
        logic [7:0]  rdata;
    } vec_t;

    vec_t        vecs [9];
    logic [16:0] obs_q [$];
    logic [16:0] exp_q [$];

    // Reference model: SDRAM contents plus per-line tag/valid/dirty/data
    logic [7:0]  mem_m   [65536];
    logic [7:0]  m_line  [8][32];
    logic [7:0]  m_tag   [8];
    logic        m_valid [8];
    logic        m_dirty [8];

    // Record every SDRAM strobe as {wr_rd, address}
    always @(negedge clk) begin
        if (mstrb_sdram === 1'b1) obs_q.push_back({wr_rd_sdram, Address_sdram});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_strobes(input string name);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s strobes: got %0d pulses, expected %0d", name, obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s strobe %0d: got 0x%0h, expected 0x%0h", name, i, obs_q[i], exp_q[i]);
                    break;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic model_req(input logic wr, input logic [15:0] a, input logic [7:0] d,
                             output int lat, output logic [7:0] rd);
        logic [2:0] idx;
        logic [7:0] tg;
        logic [4:0] off;
        idx = a[7:5];
        tg  = a[15:8];
        off = a[4:0];
        exp_q.delete();
        lat = 3;
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            lat = 67;
            if (m_dirty[idx]) begin
                lat = 131;
                for (int o = 0; o < 32; o++) begin
                    mem_m[{m_tag[idx], idx, 5'(o)}] = m_line[idx][o];
                    exp_q.push_back({1'b1, m_tag[idx], idx, 5'(o)});
                end
            end
            for (int o = 0; o < 32; o++) begin
                m_line[idx][o] = mem_m[{tg, idx, 5'(o)}];
                exp_q.push_back({1'b0, tg, idx, 5'(o)});
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
        end
        if (wr) begin
            m_line[idx][off] = d;
            m_dirty[idx]     = 1'b1;
            rd               = 8'h00;
        end else begin
            rd = m_line[idx][off];
        end
    endtask

    // Issue one request and count cycles from the accepting edge to rdy_cpu=1.
    // A non-zero glitch_at re-asserts cs_cpu that many cycles into the request.
    task automatic run_req(input logic wr, input logic [15:0] a, input logic [7:0] d,
                           input int glitch_at, output int lat, output logic [7:0] rd);
        int w;
        w = 0;
        while (rdy_cpu !== 1'b1 && w < 400) begin
            @(posedge clk); #1;
            w++;
        end
        if (rdy_cpu !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rdy_wait: rdy_cpu=%b after %0d cycles, expected 1", rdy_cpu, w);
        end
        obs_q.delete();
        wr_rd_cpu   = wr;
        Address_cpu = a;
        DOut_cpu    = d;
        cs_cpu      = 1'b1;
        @(posedge clk); #1;
        cs_cpu = 1'b0;
        lat    = 0;
        while (lat < 400) begin
            @(posedge clk); #1;
            lat++;
            if (glitch_at > 0 && lat == glitch_at) begin
                cs_cpu      = 1'b1;
                wr_rd_cpu   = 1'b1;
                Address_cpu = 16'h7777;
                DOut_cpu    = 8'hEE;
            end
            if (glitch_at > 0 && lat == glitch_at + 2) cs_cpu = 1'b0;
            if (rdy_cpu === 1'b1) break;
        end
        cs_cpu = 1'b0;
        rd     = DIn_cpu;
    endtask

    task automatic do_req(input string name, input logic wr, input logic [15:0] a,
                          input logic [7:0] d, input int glitch_at);
        int         lat, elat;
        logic [7:0] rd, erd;
        model_req(wr, a, d, elat, erd);
        run_req(wr, a, d, glitch_at, lat, rd);
        check({name, " latency"}, 64'(lat), 64'(elat));
        if (!wr) check({name, " rdata"}, 64'(rd), 64'(erd));
        check_strobes(name);
    endtask

    function automatic logic [63:0] out_bundle();
        return 64'({rdy_cpu, DIn_cpu, Address_sdram, wr_rd_sdram, mstrb_sdram,
                    mux_sel, demux_sel, wen_sram, address_cache_ctrl_sram});
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         lat;
        logic [7:0] rd;
        logic [7:0] tag_pool [4];
        int         hi;

        vecs[0] = '{1'b0, 16'h1234, 8'h00, 67,  8'h34};
        vecs[1] = '{1'b0, 16'h1235, 8'h00, 3,   8'h35};
        vecs[2] = '{1'b1, 16'h1235, 8'hAB, 3,   8'h00};
        vecs[3] = '{1'b0, 16'h3235, 8'h00, 131, 8'h35};
        vecs[4] = '{1'b0, 16'h1235, 8'h00, 67,  8'hAB};
        vecs[5] = '{1'b1, 16'h00FF, 8'h5A, 67,  8'h00};
        vecs[6] = '{1'b0, 16'h00FF, 8'h00, 3,   8'h5A};
        vecs[7] = '{1'b0, 16'h01E0, 8'h00, 131, 8'hE0};
        vecs[8] = '{1'b0, 16'h00FF, 8'h00, 67,  8'h5A};

        tag_pool[0] = 8'h12;
        tag_pool[1] = 8'h32;
        tag_pool[2] = 8'h55;
        tag_pool[3] = 8'hA0;

        for (int i = 0; i < 65536; i++) mem_m[i] = i[7:0];
        model_reset();

        rst         = 1'b1;
        cs_cpu      = 1'b0;
        wr_rd_cpu   = 1'b0;
        Address_cpu = 16'h0000;
        DOut_cpu    = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset outputs", out_bundle(), 64'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rdy after reset", 64'(rdy_cpu), 64'h1);

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            model_req(vecs[i].wr, vecs[i].addr, vecs[i].data, lat, rd);
            run_req(vecs[i].wr, vecs[i].addr, vecs[i].data, 0, lat, rd);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
            if (!vecs[i].wr) check($sformatf("vec%0d rdata", i), 64'(rd), 64'(vecs[i].rdata));
            check_strobes($sformatf("vec%0d", i));
        end

        // Reset in the middle of an allocate burst for 0x4444
        wr_rd_cpu   = 1'b0;
        Address_cpu = 16'h4444;
        cs_cpu      = 1'b1;
        @(posedge clk); #1;
        cs_cpu = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid-burst reset outputs", out_bundle(), 64'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check("rdy low before first edge", 64'(rdy_cpu), 64'h0);
        @(posedge clk); #1;
        check("rdy one cycle after release", 64'(rdy_cpu), 64'h1);
        do_req("post-reset read", 1'b0, 16'h4444, 8'h00, 0);

        // cs_cpu pulsed while busy must be dropped, not queued
        do_req("busy cs ignored", 1'b0, 16'h5566, 8'h00, 10);
        hi = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rdy_cpu === 1'b1) hi++;
        end
        check("no queued request", 64'(hi), 64'd4);
        do_req("after ignored cs", 1'b0, 16'h7777, 8'h00, 0);

        // Random traffic over a handful of tags to force hits and both miss kinds
        for (int n = 0; n < 40; n++) begin
            logic [15:0] a;
            logic        w;
            logic [7:0]  d;
            a = {tag_pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
            w = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            do_req($sformatf("rand%0d", n), w, a, d, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_top.md
CACHE_TOP -- requirements
Module: cache_top

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH 16, CPU/SDRAM address width; DATA_WIDTH 8, byte width; ADDR_WIDTH_SRAM 8, cache SRAM address width; TAG_SIZE 8, tag width; DEPTH 8, number of cache lines.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 Address_cpu  in  16  CPU address; tag [15:8], index [7:5], offset [4:0].
REQ-006 DOut_cpu  in  8  CPU write data.
REQ-007 wr_rd_cpu  in  1  1=write, 0=read.
REQ-008 cs_cpu  in  1  request strobe.
REQ-009 rdy_cpu  out  1  controller idle and able to accept a request.
REQ-010 DIn_cpu  out  8  read data returned to CPU; valid when rdy_cpu rises after a read.
REQ-011 Address_sdram  out  16  SDRAM byte address.
REQ-012 wr_rd_sdram  out  1  1=SDRAM write, 0=SDRAM read.
REQ-013 mstrb_sdram  out  1  one-cycle SDRAM byte strobe.
REQ-014 mux_sel  out  1  SRAM write-data source: 0=CPU, 1=SDRAM.
REQ-015 demux_sel  out  1  SRAM read-data sink: 0=CPU, 1=SDRAM.
REQ-016 wen_sram  out  1  cache SRAM write enable.
REQ-017 address_cache_ctrl_sram  out  8  cache SRAM address {index, offset}.

Function
REQ-018 Contents SHALL be: controller FSM; 256x8 cache SRAM; 8-entry tag array with valid and dirty bits; internal 65536x8 SDRAM model, initialised at time zero so that byte at address A equals A[7:0] and not altered by reset.
REQ-019 Cache organisation SHALL be direct-mapped, 8 lines of 32 bytes, write-back with write-allocate.
REQ-020 FSM states SHALL be IDLE, COMPARE, ACCESS, WRITEBACK, ALLOCATE.
REQ-021 IDLE: rdy_cpu=1; when cs_cpu=1, latch address, data and wr_rd; go to COMPARE; rdy_cpu=0 from the next cycle.
REQ-022 COMPARE (1 cycle): hit = valid[index] and tag match.
  - Hit: go to ACCESS.
  - Miss with dirty line: go to WRITEBACK.
  - Miss with clean line: go to ALLOCATE.
REQ-023 ACCESS (1 cycle), SRAM address {index, offset}:
  - Write: mux_sel=0, wen_sram=1, set dirty[index].
  - Read: demux_sel=0, wen_sram=0, DIn_cpu captured from SRAM.
  - Next state: IDLE.
REQ-024 WRITEBACK SHALL transfer 32 bytes, offsets 0..31, 2 cycles per byte.
  - Cycle A: demux_sel=1, wr_rd_sdram=1, mstrb_sdram=1, Address_sdram={old tag, index, offset}; SDRAM written with SRAM byte.
  - Cycle B: mstrb_sdram=0.
  - After offset 31: clear dirty[index], go to ALLOCATE.
REQ-025 ALLOCATE SHALL transfer 32 bytes, 2 cycles per byte.
  - Cycle A: wr_rd_sdram=0, mstrb_sdram=1, Address_sdram={new tag, index, offset}.
  - Cycle B: mux_sel=1, wen_sram=1; SRAM written with SDRAM byte.
  - After offset 31: tag[index]=new tag, valid=1, dirty=0, go to ACCESS.
REQ-026 Latency SHALL be counted from the IDLE edge sampling cs_cpu to rdy_cpu=1.
  - Hit: 3 cycles.
  - Clean miss: 67 cycles.
  - Dirty miss: 131 cycles.
REQ-027 cs_cpu SHALL be ignored while rdy_cpu=0; no request queuing.
REQ-028 Outside the active cycles above, SHALL drive mstrb_sdram=0, wen_sram=0, mux_sel=0, demux_sel=0, wr_rd_sdram=0.
REQ-029 The SRAM address SHALL equal the latched index concatenated with the running transfer offset (burst) or the CPU offset (ACCESS).

Reset
REQ-030 While rst=1, SHALL force state IDLE and clear all valid and dirty bits.
REQ-031 While rst=1, SHALL drive rdy_cpu=0, DIn_cpu=0, Address_sdram=0, address_cache_ctrl_sram=0, and all strobes/selects 0; rdy_cpu=1 first cycle after rst=0.
REQ-032 Reset asserted mid-burst SHALL abort the burst; no SDRAM or SRAM writes occur in the reset cycle.

Verification
REQ-033 After reset, read 0x1234 (clean miss) -> 32 mstrb pulses with wr_rd_sdram=0, Address_sdram 0x1220..0x123F; DIn_cpu=0x34; rdy low 67 cycles.
REQ-034 Then read 0x1235 -> hit, no mstrb pulses, DIn_cpu=0x35, 3-cycle latency.
REQ-035 Write 0xAB to 0x1235, then read 0x3235 (same index, dirty) -> 32 write strobes at 0x1220..0x123F, then 32 reads at 0x3220..0x323F; DIn_cpu=0x35.
REQ-036 Read 0x1235 again -> miss; returns 0xAB (write-back preserved data).
REQ-037 Assert rst during an ALLOCATE burst -> rdy_cpu=1 one cycle after release; next read of the same address is a miss.
